wb_skid_stage: RTL

- Parametrised writeback pipeline register that replaces a plain enable-gated register with a valid/ready handshake and a 2-entry skid buffer.
- Sits between the memory stage and the register file write port.
- Absorbs one cycle of downstream back-pressure without combinational ready propagation.
- Supports pipeline flush and provides a combinational bypass-query port so earlier stages can forward pending writeback data.

---
 rtl/wb_pkg.sv | 18 +
 rtl/wb_skid_stage_if.sv | 35 +++
 rtl/wb_skid_stage_bypass.sv | 36 +++
 rtl/wb_skid_stage.sv | 127 ++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared writeback definitions: default widths, the entry record and the
// architectural zero-register address used by the optional zero-register
// filter (WB_ZERO_REG_FILTER_EN).
package wb_pkg;

    localparam int unsigned WB_DATA_W    = 32;
    localparam int unsigned WB_ADDR_W    = 5;
    localparam int unsigned WB_ZERO_ADDR = 0;

    // Writeback entry at the default widths; parametrised users declare an
    // equivalent local record sized from their own parameters.
    typedef struct packed {
        logic [WB_DATA_W-1:0] data;
        logic [WB_ADDR_W-1:0] addr;
        logic                 write;
    } wb_entry_t;

endpackage

// File: rtl/wb_skid_stage_if.sv
// Bus bundle for the writeback skid stage: flush, upstream and downstream
// handshakes, bypass query and occupancy. The stage uses the slave modport;
// the producer/consumer side uses master.
interface wb_skid_stage_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5
);
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [ADDR_W-1:0] in_addr;
    logic              in_write;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [ADDR_W-1:0] out_addr;
    logic              out_write;
    logic [ADDR_W-1:0] q_addr;
    logic              q_hit;
    logic [DATA_W-1:0] q_data;
    logic [1:0]        occupancy;

    modport slave (
        input  flush, in_valid, in_data, in_addr, in_write, out_ready, q_addr,
        output in_ready, out_valid, out_data, out_addr, out_write,
               q_hit, q_data, occupancy
    );

    modport master (
        output flush, in_valid, in_data, in_addr, in_write, out_ready, q_addr,
        input  in_ready, out_valid, out_data, out_addr, out_write,
               q_hit, q_data, occupancy
    );
endinterface

// File: rtl/wb_skid_stage_bypass.sv
// wb_bypass_match: combinational priority compare of a query address against
// a younger and an older pending writeback entry. The younger entry wins.
module wb_bypass_match #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5
) (
    input  logic              young_valid,
    input  logic              young_write,
    input  logic [ADDR_W-1:0] young_addr,
    input  logic [DATA_W-1:0] young_data,
    input  logic              old_valid,
    input  logic              old_write,
    input  logic [ADDR_W-1:0] old_addr,
    input  logic [DATA_W-1:0] old_data,
    input  logic [ADDR_W-1:0] q_addr,
    output logic              hit,
    output logic [DATA_W-1:0] data
);

    logic young_match;
    logic old_match;

    // Match each entry, then select the youngest matching data (0 on miss).
    always_comb begin
        young_match = young_valid && young_write && (young_addr == q_addr);
        old_match   = old_valid && old_write && (old_addr == q_addr);
        hit         = young_match || old_match;
        data        = '0;
        if (young_match) begin
            data = young_data;
        end else if (old_match) begin
            data = old_data;
        end
    end

endmodule

// File: rtl/wb_skid_stage.sv
// wb_skid_stage: writeback pipeline register with valid/ready handshake and a
// one-entry skid buffer (two entries total). in_ready is registered and never
// depends combinationally on out_ready. Optional WB_ZERO_REG_FILTER_EN turns
// writes to the zero register into non-writing entries and masks bypass hits
// on address 0.
module wb_skid_stage
    import wb_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5
) (
    input logic            clk,
    input logic            reset,
    wb_skid_stage_if.slave bus
);

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [ADDR_W-1:0] addr;
        logic              write;
    } entry_t;

    entry_t main_q, main_d;
    entry_t skid_q, skid_d;
    entry_t in_entry;
    logic   main_valid_q, main_valid_d;
    logic   skid_valid_q, skid_valid_d;
    logic   in_ready_q, in_ready_d;
    logic   accept;
    logic   drain;
    logic   raw_hit;

    // Form the incoming entry, applying the zero-register filter if enabled.
    always_comb begin
        in_entry.data  = bus.in_data;
        in_entry.addr  = bus.in_addr;
`ifdef WB_ZERO_REG_FILTER_EN
        in_entry.write = bus.in_write && (bus.in_addr != ADDR_W'(WB_ZERO_ADDR));
`else
        in_entry.write = bus.in_write;
`endif
    end

    // Next-state for main/skid registers; flush clears valids but keeps data.
    always_comb begin
        accept       = bus.in_valid && in_ready_q;
        drain        = main_valid_q && bus.out_ready;
        main_d       = main_q;
        skid_d       = skid_q;
        main_valid_d = main_valid_q;
        skid_valid_d = skid_valid_q;
        if (bus.flush) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (!main_valid_q || drain) begin
            if (skid_valid_q) begin
                main_d       = skid_q;
                main_valid_d = 1'b1;
            end else if (accept) begin
                main_d       = in_entry;
                main_valid_d = 1'b1;
            end else begin
                main_valid_d = 1'b0;
            end
            // accept implies an empty skid, so this only fires if in_ready
            // were ever bypassed; kept to mirror the full refill rule.
            if (accept && skid_valid_q) begin
                skid_d       = in_entry;
                skid_valid_d = 1'b1;
            end else begin
                skid_valid_d = 1'b0;
            end
        end else if (accept) begin
            skid_d       = in_entry;
            skid_valid_d = 1'b1;
        end
        in_ready_d = !skid_valid_d;
    end

    // State registers; reset has priority over flush and handshakes.
    always_ff @(posedge clk) begin
        if (reset) begin
            main_q       <= '0;
            skid_q       <= '0;
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
            in_ready_q   <= 1'b1;
        end else begin
            main_q       <= main_d;
            skid_q       <= skid_d;
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
            in_ready_q   <= in_ready_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = main_valid_q;
    assign bus.out_data  = main_q.data;
    assign bus.out_addr  = main_q.addr;
    assign bus.out_write = main_q.write;
    assign bus.occupancy = {1'b0, main_valid_q} + {1'b0, skid_valid_q};

    wb_bypass_match #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W)
    ) u_bypass (
        .young_valid(skid_valid_q),
        .young_write(skid_q.write),
        .young_addr (skid_q.addr),
        .young_data (skid_q.data),
        .old_valid  (main_valid_q),
        .old_write  (main_q.write),
        .old_addr   (main_q.addr),
        .old_data   (main_q.data),
        .q_addr     (bus.q_addr),
        .hit        (raw_hit),
        .data       (bus.q_data)
    );

`ifdef WB_ZERO_REG_FILTER_EN
    assign bus.q_hit = raw_hit && (bus.q_addr != ADDR_W'(WB_ZERO_ADDR));
`else
    assign bus.q_hit = raw_hit;
`endif

endmodule
